// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM state encoding and cycle count for the multiply/divide unit
package mdu_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int CALC_CYCLES = 32;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply and divide with HI/LO result registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    logic [1:0]         state = S_IDLE;
    logic [1:0]         op_q = 2'b00;
    logic               neg_a = 1'b0;
    logic               neg_b = 1'b0;
    logic [2*WIDTH-1:0] acc = '0;
    logic [WIDTH-1:0]   opnd = '0;
    logic [5:0]         cnt = '0;
    logic [WIDTH-1:0]   hi_q = '0;
    logic [WIDTH-1:0]   lo_q = '0;
    logic               done_q = 1'b0;
    logic               sgn_in, is_div, idle;
    logic [WIDTH-1:0]   mag_a, mag_b, sub, quo, rem, fix_hi, fix_lo;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [2*WIDTH-1:0] step_acc, prod;
    logic               ge;

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;
    // the done cycle still counts as busy so a back-to-back start or MT write is held off
    assign busy = (state != S_IDLE) | done_q;

    // one shift-add / restoring shift-subtract step plus the final sign correction
    always_comb begin
        idle     = (state == S_IDLE) & ~done_q;
        sgn_in   = ~op[0];
        is_div   = op_q[1];
        mag_a    = (sgn_in & rs_data[WIDTH-1]) ? -rs_data : rs_data;
        mag_b    = (sgn_in & rt_data[WIDTH-1]) ? -rt_data : rt_data;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge       = rem_sh >= {1'b0, opnd};
        sub      = rem_sh[WIDTH-1:0] - opnd;
        step_acc = is_div ? (ge ? {sub, acc[WIDTH-2:0], 1'b1} : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0})
                          : {mul_sum, acc[WIDTH-1:1]};
        prod     = (neg_a ^ neg_b) ? -acc : acc;
        quo      = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_hi   = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        fix_lo   = is_div ? ((opnd == '0) ? '1 : quo) : prod[WIDTH-1:0];
    end

    // FSM, datapath and HI/LO update; a zero divisor leaves the dividend as remainder naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= 2'b00;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (idle && start) begin
                        op_q  <= op;
                        neg_a <= sgn_in & rs_data[WIDTH-1];
                        neg_b <= sgn_in & rt_data[WIDTH-1];
                        acc   <= {{WIDTH{1'b0}}, mag_a};
                        opnd  <= mag_b;
                        cnt   <= '0;
                        state <= S_CALC;
                    end else if (idle) begin
                        if (hi_we) hi_q <= mt_data;
                        if (lo_we) lo_q <= mt_data;
                    end
                end
                S_CALC: begin
                    acc <= step_acc;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(CALC_CYCLES - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit timing, arithmetic, MT writes and reset
module tb_mult_div_unit;
    import mdu_pkg::*;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] mt_data = '0;
    logic [31:0] hi, lo;
    logic        busy, done;
    int          errors = 0;
    int          checks = 0;
    sb_t         sb[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
        .mt_data(mt_data), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_v;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        case (o)
            OP_MULT:  return 64'(sa * sb_v);
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV:   return (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb_v), 32'(sa / sb_v)};
            default:  return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
        endcase
    endfunction

    // scoreboard: every done pulse pops one expected HI:LO pair
    always begin
        sb_t e;
        @(posedge clk);
        #1;
        if (done) begin
            if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                check(e.tag, {hi, lo}, e.exp);
            end
        end
    end

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string tag);
        int k, nb, dat;
        sb.push_back('{tag, exp});
        @(negedge clk);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nb = 0; dat = -1; k = 0;
        while (busy && k < 100) begin
            if (done) dat = k;
            nb++;
            @(posedge clk);
            #1 k++;
        end
        check({tag, "_busy_cycles"}, 64'(nb), 64'd34);
        check({tag, "_done_cycle"}, 64'(dat), 64'd33);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle_timeout"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b, hold_hi, hold_lo;
        logic [1:0]  o;
        #3;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // first edge after reset release accepts a start
        run(OP_MULT,  32'hFFFFFFFE, 32'd3,        64'hFFFFFFFF_FFFFFFFA, "mult_neg");
        run(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max");
        run(OP_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, "div_neg");
        run(OP_DIVU,  32'd100,      32'd0,        64'h00000064_FFFFFFFF, "divu_zero");
        run(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_ovf");
        run(OP_DIV,   32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF, "div_zero_neg");
        run(OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult_minmin");
        run(OP_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_pos_neg");
        for (int i = 0; i < 6; i++) begin
            o = 2'(i % 4);
            a = $urandom();
            b = (i == 5) ? 32'd13 : $urandom();
            run(o, a, b, model(o, a, b), $sformatf("rand%0d", i));
        end
        // start and hi_we mid-CALC are ignored, HI/LO hold
        sb.push_back('{"multu_5x7", 64'd35});
        @(negedge clk);
        op = OP_MULTU; rs_data = 32'd5; rt_data = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hold_hi = hi; hold_lo = lo;
        repeat (5) @(negedge clk);
        op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd0; start = 1'b1; hi_we = 1'b1; mt_data = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("hold_during_calc", {hi, lo}, {hold_hi, hold_lo});
        wait_idle("multu_5x7");
        repeat (3) @(negedge clk);
        check("busy_after_ignored_start", 64'(busy), 64'd0);
        hi_we = 1'b1; mt_data = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", {hi, lo}, {32'h1234, 32'd35});
        // start wins over a same-cycle MT write
        sb.push_back('{"start_beats_mt", 64'd6});
        @(negedge clk);
        op = OP_MULT; rs_data = 32'd2; rt_data = 32'd3; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'hFFFF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        wait_idle("start_beats_mt");
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'hAAAA5555;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both", {hi, lo}, {32'hAAAA5555, 32'hAAAA5555});
        // reset mid-CALC abandons the divide
        @(negedge clk);
        op = OP_DIV; rs_data = 32'd1000; rt_data = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        #1;
        check("midreset_outputs", {hi, lo}, 64'd0);
        check("midreset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run(OP_MULT, 32'd6, 32'd7, 64'd42, "mult_after_reset");
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
